// File: rtl/pre_arbiter_q_if.sv
// ---------------------------------------------------------------------------
// pre_arbiter_q_if
// Bundles the descriptor input, the arbiter handshake and the status outputs
// of one ingress descriptor queue.
//   slave  : the queue side (consumes descriptors, drives request/fields/status)
//   master : the packet-memory / arbiter side (drives descriptors, grant, done)
// Signals:
//   i_desc_valid/len/addr/port/err : descriptor strobe and payload
//   o_desc_ready                   : queue not full
//   o_request, o_length,
//   o_start_adress, o_port_num     : presented descriptor towards the arbiter
//   i_grant, i_done                : arbiter handshake
//   o_level, o_drop_cnt, o_overflow: status
// ---------------------------------------------------------------------------
interface pre_arbiter_q_if #(
  parameter int pFIFO_WIDTH = 11,
  parameter int pDEPTH_RAM  = 4096,
  parameter int pPORT_W     = 2,
  parameter int pDESC_DEPTH = 8,
  parameter int pCNT_W      = 16
);
  localparam int AW  = $clog2(pDEPTH_RAM);
  localparam int LVW = $clog2(pDESC_DEPTH) + 1;

  logic                   i_desc_valid;
  logic [pFIFO_WIDTH-1:0] i_desc_len;
  logic [AW-1:0]          i_desc_addr;
  logic [pPORT_W-1:0]     i_desc_port;
  logic                   i_desc_err;
  logic                   o_desc_ready;
  logic                   o_request;
  logic [pFIFO_WIDTH-1:0] o_length;
  logic [AW-1:0]          o_start_adress;
  logic [pPORT_W-1:0]     o_port_num;
  logic                   i_grant;
  logic                   i_done;
  logic [LVW-1:0]         o_level;
  logic [pCNT_W-1:0]      o_drop_cnt;
  logic                   o_overflow;

  modport slave (
    input  i_desc_valid, i_desc_len, i_desc_addr, i_desc_port, i_desc_err,
    input  i_grant, i_done,
    output o_desc_ready, o_request, o_length, o_start_adress, o_port_num,
    output o_level, o_drop_cnt, o_overflow
  );

  modport master (
    output i_desc_valid, i_desc_len, i_desc_addr, i_desc_port, i_desc_err,
    output i_grant, i_done,
    input  o_desc_ready, o_request, o_length, o_start_adress, o_port_num,
    input  o_level, o_drop_cnt, o_overflow
  );
endinterface

// File: rtl/pre_arbiter_q.sv
// ---------------------------------------------------------------------------
// pre_arbiter_q
// Per-ingress-port descriptor queue sitting between packet memory and the
// switch arbiter. Buffers up to pDESC_DEPTH descriptors {len, addr, port},
// optionally discards errored / zero-length ones, and offers the oldest
// queued descriptor to the arbiter with a request/grant/done handshake.
// Ports:
//   iclk  : clock
//   i_rst : synchronous reset, active low
//   bus   : pre_arbiter_q_if.slave (descriptor in, arbiter handshake, status)
// ---------------------------------------------------------------------------
module pre_arbiter_q #(
  parameter int pFIFO_WIDTH = 11,
  parameter int pDEPTH_RAM  = 4096,
  parameter int pPORT_W     = 2,
  parameter int pDESC_DEPTH = 8,
  parameter int pDROP_ERR   = 1,
  parameter int pCNT_W      = 16
) (
  input  logic           iclk,
  input  logic           i_rst,
  pre_arbiter_q_if.slave bus
);
  localparam int AW  = $clog2(pDEPTH_RAM);
  localparam int PW  = $clog2(pDESC_DEPTH);
  localparam int LVW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  // Descriptor storage, one array per field.
  logic [pFIFO_WIDTH-1:0] r_mem_len  [pDESC_DEPTH];
  logic [AW-1:0]          r_mem_addr [pDESC_DEPTH];
  logic [pPORT_W-1:0]     r_mem_port [pDESC_DEPTH];

  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [LVW-1:0]         r_level;
  logic [pCNT_W-1:0]      r_drop_cnt;
  logic                   r_overflow;

  state_t                 r_state;
  logic                   r_request;
  logic [pFIFO_WIDTH-1:0] r_length;
  logic [AW-1:0]          r_start_addr;
  logic [pPORT_W-1:0]     r_port_num;

  logic w_full;
  logic w_empty;
  logic w_bad;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_level == LVW'(pDESC_DEPTH));
  assign w_empty = (r_level == '0);

  // Errored or empty packets are only filtered when pDROP_ERR is set.
  assign w_bad  = (pDROP_ERR != 0) &&
                  (bus.i_desc_err || (bus.i_desc_len == '0));
  assign w_push = bus.i_desc_valid && !w_full && !w_bad;
  // The head stays in the queue while it is being offered, so a grant in
  // REQ always finds a valid entry to pop.
  assign w_pop  = (r_state == ST_REQ) && bus.i_grant;
  // A descriptor that is both bad and arrives while full counts once.
  assign w_drop = bus.i_desc_valid && (w_full || w_bad);

  // Storage write port; contents need no reset because pointers and level do.
  always_ff @(posedge iclk) begin
    if (w_push) begin
      r_mem_len[r_wr_ptr]  <= bus.i_desc_len;
      r_mem_addr[r_wr_ptr] <= bus.i_desc_addr;
      r_mem_port[r_wr_ptr] <= bus.i_desc_port;
    end
  end

  // Pointers, occupancy and drop bookkeeping.
  always_ff @(posedge iclk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Depth is a power of two, so the pointers wrap by overflowing.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVW'(1);
        2'b01:   r_level <= r_level - LVW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + pCNT_W'(1);
      if (bus.i_desc_valid && w_full)   r_overflow <= 1'b1;
    end
  end

  // Arbiter handshake; request and fields are registered so they stay stable
  // for the whole REQ phase.
  always_ff @(posedge iclk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_request    <= 1'b0;
      r_length     <= '0;
      r_start_addr <= '0;
      r_port_num   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_length     <= r_mem_len[r_rd_ptr];
            r_start_addr <= r_mem_addr[r_rd_ptr];
            r_port_num   <= r_mem_port[r_rd_ptr];
            r_request    <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.i_grant) begin
            r_request <= 1'b0;
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (bus.i_done) r_state <= ST_IDLE;
        end
        default: begin
          r_request <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_desc_ready   = !w_full;
  assign bus.o_request      = r_request;
  assign bus.o_length       = r_length;
  assign bus.o_start_adress = r_start_addr;
  assign bus.o_port_num     = r_port_num;
  assign bus.o_level        = r_level;
  assign bus.o_drop_cnt     = r_drop_cnt;
  assign bus.o_overflow     = r_overflow;

endmodule

// File: tb/tb_pre_arbiter_q.sv
// ---------------------------------------------------------------------------
// tb_pre_arbiter_q
// Directed bench for pre_arbiter_q. dut0 drops bad descriptors (pDROP_ERR=1);
// dut1 forwards them (pDROP_ERR=0) and sees the same stimulus as dut0.
// ---------------------------------------------------------------------------
module tb_pre_arbiter_q;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  pre_arbiter_q_if bus0 ();
  pre_arbiter_q_if bus1 ();

  pre_arbiter_q #(.pDROP_ERR(1)) dut0 (.iclk(clk), .i_rst(rst_n), .bus(bus0));
  pre_arbiter_q #(.pDROP_ERR(0)) dut1 (.iclk(clk), .i_rst(rst_n), .bus(bus1));

  assign bus1.i_desc_valid = bus0.i_desc_valid;
  assign bus1.i_desc_len   = bus0.i_desc_len;
  assign bus1.i_desc_addr  = bus0.i_desc_addr;
  assign bus1.i_desc_port  = bus0.i_desc_port;
  assign bus1.i_desc_err   = bus0.i_desc_err;
  assign bus1.i_grant      = bus0.i_grant;
  assign bus1.i_done       = bus0.i_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int len, input int addr, input int port, input bit err);
    bus0.i_desc_len   = 11'(len);
    bus0.i_desc_addr  = 12'(addr);
    bus0.i_desc_port  = 2'(port);
    bus0.i_desc_err   = err;
    bus0.i_desc_valid = 1'b1;
    step();
    bus0.i_desc_valid = 1'b0;
    bus0.i_desc_err   = 1'b0;
  endtask

  task automatic do_reset();
    bus0.i_desc_valid = 1'b0;
    bus0.i_grant = 1'b0;
    bus0.i_done  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus0.o_request !== 1'b0) begin failed++; $display("FAIL reset_request: got %0b expected 0", bus0.o_request); end
    tests++; if (bus0.o_level !== 4'd0) begin failed++; $display("FAIL reset_level: got %0d expected 0", bus0.o_level); end
    tests++; if (bus0.o_desc_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %0b expected 1", bus0.o_desc_ready); end
    tests++; if (bus0.o_drop_cnt !== 16'd0 || bus0.o_overflow !== 1'b0) begin failed++; $display("FAIL reset_drop: got cnt=%0d ovf=%0b expected 0/0", bus0.o_drop_cnt, bus0.o_overflow); end
    tests++; if (bus0.o_length !== 11'd0 || bus0.o_start_adress !== 12'd0 || bus0.o_port_num !== 2'd0) begin failed++; $display("FAIL reset_fields: got len=%0d addr=%0h port=%0d expected 0", bus0.o_length, bus0.o_start_adress, bus0.o_port_num); end
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    do_reset();
    push(64, 'h100, 2, 1'b0);
    tests++; if (bus0.o_level !== 4'd1 || bus0.o_request !== 1'b0) begin failed++; $display("FAIL single_push: got level=%0d req=%0b expected 1/0", bus0.o_level, bus0.o_request); end
    step();
    tests++; if (bus0.o_request !== 1'b1 || bus0.o_length !== 11'd64 || bus0.o_start_adress !== 12'h100 || bus0.o_port_num !== 2'd2) begin
      failed++; $display("FAIL single_req: got req=%0b len=%0d addr=%0h port=%0d expected 1/64/100/2", bus0.o_request, bus0.o_length, bus0.o_start_adress, bus0.o_port_num); end
    step();
    tests++; if (bus0.o_request !== 1'b1 || bus0.o_length !== 11'd64) begin failed++; $display("FAIL single_hold: got req=%0b len=%0d expected 1/64", bus0.o_request, bus0.o_length); end
    bus0.i_grant = 1'b1; step(); bus0.i_grant = 1'b0;
    tests++; if (bus0.o_request !== 1'b0 || bus0.o_level !== 4'd0) begin failed++; $display("FAIL single_grant: got req=%0b level=%0d expected 0/0", bus0.o_request, bus0.o_level); end
    tests++; if (bus0.o_length !== 11'd64) begin failed++; $display("FAIL single_xfer_len: got %0d expected 64", bus0.o_length); end
    bus0.i_done = 1'b1; step(); bus0.i_done = 1'b0;
    step(); step();
    tests++; if (bus0.o_request !== 1'b0) begin failed++; $display("FAIL single_idle: got req=%0b expected 0", bus0.o_request); end
    $display("[TB] single packet len=64 addr=100 port=2");
  endtask

  task automatic test_order_wrap();
    int exp_n;
    int pushed;
    do_reset();
    exp_n = 0; pushed = 0;
    bus0.i_grant = 1'b1; bus0.i_done = 1'b1;
    for (int cyc = 0; cyc < 200 && exp_n < 12; cyc++) begin
      if (bus0.o_request === 1'b1) begin
        tests++;
        if (bus0.o_length !== 11'(exp_n + 1) || bus0.o_start_adress !== 12'(exp_n * 16) || bus0.o_port_num !== 2'(exp_n % 4)) begin
          failed++; $display("FAIL order_req%0d: got len=%0d addr=%0h port=%0d expected %0d/%0h/%0d", exp_n, bus0.o_length, bus0.o_start_adress, bus0.o_port_num, exp_n + 1, exp_n * 16, exp_n % 4); end
        $display("[TB] order request len=%0d", bus0.o_length);
        exp_n++;
      end
      if (pushed < 12 && (cyc % 2) == 0) begin
        bus0.i_desc_len   = 11'(pushed + 1);
        bus0.i_desc_addr  = 12'(pushed * 16);
        bus0.i_desc_port  = 2'(pushed % 4);
        bus0.i_desc_err   = 1'b0;
        bus0.i_desc_valid = 1'b1;
        pushed++;
      end else begin
        bus0.i_desc_valid = 1'b0;
      end
      step();
    end
    bus0.i_desc_valid = 1'b0; bus0.i_grant = 1'b0; bus0.i_done = 1'b0;
    tests++; if (exp_n != 12) begin failed++; $display("FAIL order_count: got %0d requests expected 12", exp_n); end
    tests++; if (bus0.o_drop_cnt !== 16'd0 || bus0.o_overflow !== 1'b0) begin failed++; $display("FAIL order_drops: got cnt=%0d ovf=%0b expected 0/0", bus0.o_drop_cnt, bus0.o_overflow); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push(i + 1, i, i % 4, 1'b0);
    tests++; if (bus0.o_level !== 4'd8 || bus0.o_desc_ready !== 1'b0) begin failed++; $display("FAIL full_level: got level=%0d ready=%0b expected 8/0", bus0.o_level, bus0.o_desc_ready); end
    tests++; if (bus0.o_overflow !== 1'b0 || bus0.o_drop_cnt !== 16'd0) begin failed++; $display("FAIL full_preovf: got ovf=%0b cnt=%0d expected 0/0", bus0.o_overflow, bus0.o_drop_cnt); end
    push(9, 9, 1, 1'b0);
    tests++; if (bus0.o_level !== 4'd8 || bus0.o_desc_ready !== 1'b0) begin failed++; $display("FAIL ovf_level: got level=%0d ready=%0b expected 8/0", bus0.o_level, bus0.o_desc_ready); end
    tests++; if (bus0.o_overflow !== 1'b1 || bus0.o_drop_cnt !== 16'd1) begin failed++; $display("FAIL ovf_flags: got ovf=%0b cnt=%0d expected 1/1", bus0.o_overflow, bus0.o_drop_cnt); end
    step(); step();
    tests++; if (bus0.o_overflow !== 1'b1 || bus0.o_request !== 1'b1 || bus0.o_length !== 11'd1) begin failed++; $display("FAIL ovf_sticky: got ovf=%0b req=%0b len=%0d expected 1/1/1", bus0.o_overflow, bus0.o_request, bus0.o_length); end
    $display("[TB] full/overflow level=%0d drops=%0d", bus0.o_level, bus0.o_drop_cnt);
  endtask

  task automatic test_err_drop();
    int exp1 [3];
    int n0;
    int n1;
    exp1 = '{5, 0, 7};
    n0 = 0; n1 = 0;
    do_reset();
    push(5, 'h10, 0, 1'b1);
    push(0, 'h18, 3, 1'b0);
    push(7, 'h20, 1, 1'b0);
    tests++; if (bus0.o_drop_cnt !== 16'd2 || bus0.o_level !== 4'd1) begin failed++; $display("FAIL err_drop0: got cnt=%0d level=%0d expected 2/1", bus0.o_drop_cnt, bus0.o_level); end
    tests++; if (bus1.o_drop_cnt !== 16'd0 || bus1.o_level !== 4'd3) begin failed++; $display("FAIL err_keep1: got cnt=%0d level=%0d expected 0/3", bus1.o_drop_cnt, bus1.o_level); end
    bus0.i_grant = 1'b1; bus0.i_done = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus0.o_request === 1'b1) begin
        tests++;
        if (n0 != 0 || bus0.o_length !== 11'd7 || bus0.o_start_adress !== 12'h20) begin failed++; $display("FAIL err_req0_%0d: got len=%0d addr=%0h expected only len=7 addr=20", n0, bus0.o_length, bus0.o_start_adress); end
        $display("[TB] drop-mode request len=%0d", bus0.o_length);
        n0++;
      end
      if (bus1.o_request === 1'b1) begin
        tests++;
        if (n1 > 2) begin failed++; $display("FAIL err_req1_extra: got len=%0d expected no request", bus1.o_length); end
        else if (bus1.o_length !== 11'(exp1[n1])) begin failed++; $display("FAIL err_req1_%0d: got len=%0d expected %0d", n1, bus1.o_length, exp1[n1]); end
        $display("[TB] forward-mode request len=%0d", bus1.o_length);
        n1++;
      end
      step();
    end
    bus0.i_grant = 1'b0; bus0.i_done = 1'b0;
    tests++; if (n0 != 1 || n1 != 3) begin failed++; $display("FAIL err_counts: got %0d/%0d requests expected 1/3", n0, n1); end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    push(21, 'h40, 3, 1'b0);
    push(22, 'h41, 3, 1'b0);
    push(23, 'h42, 3, 1'b0);
    tests++; if (bus0.o_level !== 4'd3 || bus0.o_request !== 1'b1 || bus0.o_length !== 11'd21) begin failed++; $display("FAIL simul_pre: got level=%0d req=%0b len=%0d expected 3/1/21", bus0.o_level, bus0.o_request, bus0.o_length); end
    bus0.i_grant = 1'b1;
    bus0.i_desc_len = 11'd24; bus0.i_desc_addr = 12'h43; bus0.i_desc_port = 2'd3; bus0.i_desc_valid = 1'b1;
    step();
    bus0.i_grant = 1'b0; bus0.i_desc_valid = 1'b0;
    tests++; if (bus0.o_level !== 4'd3 || bus0.o_request !== 1'b0) begin failed++; $display("FAIL simul_level: got level=%0d req=%0b expected 3/0", bus0.o_level, bus0.o_request); end
    bus0.i_done = 1'b1; step(); bus0.i_done = 1'b0;
    tests++; if (bus0.o_request !== 1'b0) begin failed++; $display("FAIL simul_done: got req=%0b expected 0", bus0.o_request); end
    step();
    tests++; if (bus0.o_request !== 1'b1 || bus0.o_length !== 11'd22 || bus0.o_start_adress !== 12'h41) begin failed++; $display("FAIL simul_next: got req=%0b len=%0d addr=%0h expected 1/22/41", bus0.o_request, bus0.o_length, bus0.o_start_adress); end
    $display("[TB] simultaneous push/pop level=%0d next len=%0d", bus0.o_level, bus0.o_length);
  endtask

  task automatic test_reset_xfer();
    do_reset();
    push(99, 'h7, 1, 1'b1);
    for (int i = 0; i < 5; i++) push(31 + i, 'h200 + i, 1, 1'b0);
    bus0.i_grant = 1'b1; step(); bus0.i_grant = 1'b0;
    tests++; if (bus0.o_level !== 4'd4 || bus0.o_request !== 1'b0 || bus0.o_drop_cnt !== 16'd1) begin failed++; $display("FAIL rstx_pre: got level=%0d req=%0b cnt=%0d expected 4/0/1", bus0.o_level, bus0.o_request, bus0.o_drop_cnt); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    tests++; if (bus0.o_level !== 4'd0 || bus0.o_drop_cnt !== 16'd0 || bus0.o_overflow !== 1'b0 || bus0.o_desc_ready !== 1'b1) begin failed++; $display("FAIL rstx_status: got level=%0d cnt=%0d ovf=%0b ready=%0b expected 0/0/0/1", bus0.o_level, bus0.o_drop_cnt, bus0.o_overflow, bus0.o_desc_ready); end
    tests++; if (bus0.o_request !== 1'b0 || bus0.o_length !== 11'd0 || bus0.o_start_adress !== 12'd0 || bus0.o_port_num !== 2'd0) begin failed++; $display("FAIL rstx_fields: got req=%0b len=%0d addr=%0h port=%0d expected 0", bus0.o_request, bus0.o_length, bus0.o_start_adress, bus0.o_port_num); end
    bus0.i_done = 1'b1; step(); bus0.i_done = 1'b0;
    step();
    tests++; if (bus0.o_request !== 1'b0 || bus0.o_level !== 4'd0) begin failed++; $display("FAIL rstx_done_ignored: got req=%0b level=%0d expected 0/0", bus0.o_request, bus0.o_level); end
    push(40, 'h300, 2, 1'b0);
    step();
    tests++; if (bus0.o_request !== 1'b1 || bus0.o_length !== 11'd40) begin failed++; $display("FAIL rstx_idle: got req=%0b len=%0d expected 1/40", bus0.o_request, bus0.o_length); end
    $display("[TB] reset during transfer, new request len=%0d", bus0.o_length);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    bus0.i_desc_valid = 1'b0;
    bus0.i_desc_len   = '0;
    bus0.i_desc_addr  = '0;
    bus0.i_desc_port  = '0;
    bus0.i_desc_err   = 1'b0;
    bus0.i_grant      = 1'b0;
    bus0.i_done       = 1'b0;
    test_reset();
    test_single();
    test_order_wrap();
    test_full_overflow();
    test_err_drop();
    test_simul_push_pop();
    test_reset_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pre_arbiter_q.md
# pre_arbiter_q

Per-ingress-port descriptor queue between the packet memory and the switch arbiter. It accepts one descriptor per received packet (length, start address, destination port, error flag) and buffers up to pDESC_DEPTH of them. It presents the oldest good descriptor to the arbiter with a request/grant/done handshake, so reception continues while earlier packets wait for arbitration. It optionally discards errored descriptors and counts the drops.

## Interface
Parameters:
- pFIFO_WIDTH, 11: packet length width, in bytes.
- pDEPTH_RAM, 4096: packet RAM depth; the address width is $clog2(pDEPTH_RAM).
- pPORT_W, 2: destination port number width.
- pDESC_DEPTH, 8: descriptor queue depth; power of two, at least 2.
- pDROP_ERR, 1: 1 discards errored or zero-length descriptors; 0 forwards them.
- pCNT_W, 16: drop counter width.

Ports:
- iclk  in  1  clock; single clock domain.
- i_rst  in  1  reset, synchronous, active-low.
- i_desc_valid  in  1  descriptor strobe from the packet memory; one cycle per packet.
- i_desc_len  in  pFIFO_WIDTH  packet length.
- i_desc_addr  in  $clog2(pDEPTH_RAM)  packet start address.
- i_desc_port  in  pPORT_W  destination port.
- i_desc_err  in  1  CRC or receive error for this packet.
- o_desc_ready  out  1  queue can accept; combinational, equals !full.
- o_request  out  1  request to the arbiter.
- o_length  out  pFIFO_WIDTH  length of the presented descriptor.
- o_start_adress  out  $clog2(pDEPTH_RAM)  start address of the presented descriptor.
- o_port_num  out  pPORT_W  destination of the presented descriptor.
- i_grant  in  1  arbiter grant; sampled only in REQ.
- i_done  in  1  arbiter finished copying the packet; sampled only in XFER.
- o_level  out  $clog2(pDESC_DEPTH)+1  queue occupancy.
- o_drop_cnt  out  pCNT_W  dropped-descriptor count; saturates.
- o_overflow  out  1  sticky; set when i_desc_valid arrives while full.

## Operation
- Queue: circular buffer of {len, addr, port}, with wrapping read and write pointers and a separate occupancy counter.
- Push condition: i_desc_valid & !full & !bad.
  - bad = pDROP_ERR & (i_desc_err | i_desc_len==0).
  - With pDROP_ERR=0, bad is never true and every descriptor is queued.
- A bad descriptor is not written; o_drop_cnt increments by 1 and stops at all-ones.
- i_desc_valid while full: the descriptor is lost, o_overflow is set (cleared only by reset), and o_drop_cnt increments.
- Push and pop on the same edge: occupancy is unchanged and both pointers advance. Legal at any level except full, where no push is accepted.
- FSM states: IDLE, REQ, XFER.
  - IDLE: if the queue is non-empty, load o_length, o_start_adress and o_port_num from the head, set o_request=1, and go to REQ.
  - REQ: hold o_request and all o_* fields stable. On i_grant, pop the head, clear o_request, and go to XFER.
  - XFER: o_request=0 and the fields hold their last value. On i_done, go to IDLE.
- i_grant outside REQ and i_done outside XFER are ignored.
- Reset (i_rst=0 at an edge), including mid-operation:
  - pointers, level, o_request, o_drop_cnt, o_overflow, o_length, o_start_adress and o_port_num all go to 0;
  - state goes to IDLE and all queued descriptors are discarded.

## Timing
- Push on edge E into an empty queue: o_level=1 after E; o_request=1 after E+1.
- Grant sampled on edge G: o_request=0 and o_level decremented after G.
- Done sampled on edge D: IDLE after D. If the queue is non-empty, the next o_request=1 after D+1.
- Minimum spacing between request rising edges is 3 cycles (G, D=G+1, D+1).
- o_request is never deasserted before grant, and the o_* fields never change while o_request=1.
- o_desc_ready reflects the occupancy after the previous edge; it has no same-cycle dependence on pop.

## Test plan
- Single packet: push len=64, addr=0x100, port=2. Response: o_request=1 two edges later with those fields; grant → o_request=0, o_level=0; done → IDLE.
- Ordering and wrap: with pDESC_DEPTH=8, push 12 descriptors (len=1..12) while granting and doing continuously. Response: requests present len 1..12 in order; no drops.
- Full and overflow: push 9 with no grant. Response: o_level=8, o_desc_ready=0, the 9th is lost, o_overflow=1, o_drop_cnt=1.
- Error drop: with pDROP_ERR=1, push err=1, then len=0, then a good descriptor. Response: o_drop_cnt=2 and only the good one is requested. With pDROP_ERR=0, all three are requested.
- Simultaneous push and pop at level 3: grant and i_desc_valid on the same edge. Response: o_level stays 3 and the next request shows the second-oldest descriptor.
- Reset in XFER with level 4: i_rst=0 for one edge. Response: all outputs 0, state IDLE, o_drop_cnt=0; an i_done afterwards is ignored.
